// File: rtl/operand_fetch_stage.sv
// ID/EX operand-fetch stage: register-file addressing, MEM/WB forwarding,
// hazard stalls and the valid/ready pipeline register that feeds EX.
module operand_fetch_stage #(
   parameter int unsigned WIDTH    = 64,
   parameter logic [4:0]  ZERO_REG = 5'd31
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_rn,
   input  logic [4:0]       in_rm,
   input  logic [4:0]       in_rd,
   input  logic             in_reg_write,
   input  logic             in_use_imm,
   input  logic             in_uses_rm,
   input  logic [WIDTH-1:0] in_imm,
   output logic [4:0]       rf_rr1,
   output logic [4:0]       rf_rr2,
   input  logic [WIDTH-1:0] rf_rd1,
   input  logic [WIDTH-1:0] rf_rd2,
   input  logic             mem_reg_write,
   input  logic             mem_data_ok,
   input  logic [4:0]       mem_rd,
   input  logic [WIDTH-1:0] mem_data,
   input  logic             wb_reg_write,
   input  logic [4:0]       wb_rd,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_store,
   output logic [4:0]       out_rd,
   output logic             out_reg_write
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] store_q, store_d;
   logic [4:0]       rd_q, rd_d;
   logic             rw_q, rw_d;

   logic             ex_we, mem_pend, mem_fwd;
   logic             rn_ex, rn_mem, rm_ex, rm_mem;
   logic             rn_mem_hit, rn_wb_hit, rm_mem_hit, rm_wb_hit;
   logic             stall, advance;
   logic [WIDTH-1:0] rn_val, rm_val;

   function automatic logic src_match(input logic [4:0] src, input logic [4:0] rd,
                                      input logic we);
      return (src != ZERO_REG) && we && (src == rd);
   endfunction

   assign rf_rr1 = in_rn;
   assign rf_rr2 = in_rm;

   assign ex_we    = valid_q & rw_q;
   assign mem_pend = mem_reg_write & ~mem_data_ok;
   assign mem_fwd  = mem_reg_write & mem_data_ok;

   assign rn_ex  = src_match(in_rn, rd_q, ex_we);
   assign rn_mem = src_match(in_rn, mem_rd, mem_pend);
   assign rm_ex  = in_uses_rm & src_match(in_rm, rd_q, ex_we);
   assign rm_mem = in_uses_rm & src_match(in_rm, mem_rd, mem_pend);

   assign stall    = in_valid & (rn_ex | rn_mem | rm_ex | rm_mem);
   assign advance  = ~valid_q | out_ready;
   assign in_ready = advance & ~stall & ~flush;

   assign rn_mem_hit = src_match(in_rn, mem_rd, mem_fwd);
   assign rn_wb_hit  = src_match(in_rn, wb_rd, wb_reg_write);
   assign rm_mem_hit = in_uses_rm & src_match(in_rm, mem_rd, mem_fwd);
   assign rm_wb_hit  = in_uses_rm & src_match(in_rm, wb_rd, wb_reg_write);

   // MEM is the younger producer, so it takes priority over WB
   always_comb begin
      rn_val = rf_rd1;
      if (in_rn == ZERO_REG)  rn_val = '0;
      else if (rn_mem_hit)    rn_val = mem_data;
      else if (rn_wb_hit)     rn_val = wb_data;

      rm_val = rf_rd2;
      if (in_rm == ZERO_REG)  rm_val = '0;
      else if (rm_mem_hit)    rm_val = mem_data;
      else if (rm_wb_hit)     rm_val = wb_data;
   end

   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      store_d = store_q;
      rd_d    = rd_q;
      rw_d    = rw_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (advance && in_valid && !stall) begin
         valid_d = 1'b1;
         a_d     = rn_val;
         b_d     = in_use_imm ? in_imm : rm_val;
         store_d = rm_val;
         rd_d    = in_rd;
         rw_d    = in_reg_write;
      end else if (advance) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         store_q <= '0;
         rd_q    <= '0;
         rw_q    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         store_q <= store_d;
         rd_q    <= rd_d;
         rw_q    <= rw_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_a         = a_q;
   assign out_b         = b_q;
   assign out_store     = store_q;
   assign out_rd        = rd_q;
   assign out_reg_write = rw_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic against a behavioural forwarding/hazard model.
module tb_operand_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [4:0]  in_rn, in_rm, in_rd;
   logic        in_reg_write, in_use_imm, in_uses_rm;
   logic [63:0] in_imm;
   logic [4:0]  rf_rr1, rf_rr2;
   logic [63:0] rf_rd1, rf_rd2;
   logic        mem_reg_write, mem_data_ok;
   logic [4:0]  mem_rd;
   logic [63:0] mem_data;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [63:0] out_a, out_b, out_store;
   logic [4:0]  out_rd;
   logic        out_reg_write;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // model of the EX-side register contents
   logic        m_valid, m_rw;
   logic [63:0] m_a, m_b, m_st;
   logic [4:0]  m_rd;

   operand_fetch_stage #(.WIDTH(64), .ZERO_REG(5'd31)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
      .in_reg_write(in_reg_write), .in_use_imm(in_use_imm), .in_uses_rm(in_uses_rm),
      .in_imm(in_imm),
      .rf_rr1(rf_rr1), .rf_rr2(rf_rr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .mem_reg_write(mem_reg_write), .mem_data_ok(mem_data_ok), .mem_rd(mem_rd),
      .mem_data(mem_data),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_store(out_store),
      .out_rd(out_rd), .out_reg_write(out_reg_write)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_rn = 0; in_rm = 0; in_rd = 0; in_reg_write = 0;
      in_use_imm = 0; in_uses_rm = 0; in_imm = '0;
      rf_rd1 = '0; rf_rd2 = '0;
      mem_reg_write = 0; mem_data_ok = 0; mem_rd = 0; mem_data = '0;
      wb_reg_write = 0; wb_rd = 0; wb_data = '0;
      flush = 0; out_ready = 1;
   endtask

   task automatic instr(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                        input logic use_imm, input logic [63:0] imm);
      in_valid = 1; in_rd = rd; in_rn = rn; in_rm = rm; in_reg_write = 1;
      in_uses_rm = 1; in_use_imm = use_imm; in_imm = imm;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_a"}, out_a, 64'd0);
      chk({tag, "_b"}, out_b, 64'd0);
      chk({tag, "_store"}, out_store, 64'd0);
      chk({tag, "_rd"}, 64'(out_rd), 64'd0);
      chk({tag, "_rw"}, 64'(out_reg_write), 64'd0);
   endtask

   function automatic logic [4:0] rreg();
      int unsigned v;
      v = $urandom_range(0, 4);
      return (v == 4) ? 5'd31 : 5'(v);
   endfunction

   // value a source must receive: zero register, else youngest ready producer, else RF
   function automatic logic [63:0] want(input logic [4:0] src, input logic live,
                                        input logic [63:0] rf);
      if (src == 5'd31) return '0;
      if (live && mem_reg_write && mem_data_ok && mem_rd == src) return mem_data;
      if (live && wb_reg_write && wb_rd == src) return wb_data;
      return rf;
   endfunction

   // a source is blocked while any older producer of it has no usable result yet
   function automatic logic blocked(input logic [4:0] src, input logic live);
      if (!live || src == 5'd31) return 1'b0;
      if (m_valid && m_rw && m_rd == src) return 1'b1;
      if (mem_reg_write && !mem_data_ok && mem_rd == src) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      logic        stall, adv, exp_ready;
      logic [63:0] rmv;

      idle_inputs();
      reset = 1;
      #1;
      chk_all_zero("reset");
      tick(); tick();
      reset = 0;

      // ADD rd=2, rn=1 (X1=5), rm=ZERO
      instr(5'd2, 5'd1, 5'd31, 1'b0, '0);
      rf_rd1 = 64'd5; rf_rd2 = 64'hDEAD;
      #1;
      chk("add_in_ready", 64'(in_ready), 64'd1);
      chk("add_rr1", 64'(rf_rr1), 64'd1);
      tick();
      chk("add_valid", 64'(out_valid), 64'd1);
      chk("add_a", out_a, 64'd5);
      chk("add_b", out_b, 64'd0);
      chk("add_rd", 64'(out_rd), 64'd2);

      // asynchronous reset mid-cycle with a valid instruction held
      in_valid = 0; out_ready = 0;
      #2 reset = 1;
      #1;
      chk_all_zero("async_reset");
      tick();
      reset = 0; out_ready = 1;
      #1;
      chk("post_reset_ready", 64'(in_ready), 64'd1);

      // producer rd=3 with immediate operand
      instr(5'd3, 5'd5, 5'd6, 1'b1, 64'h10);
      rf_rd1 = 64'h50; rf_rd2 = 64'h60;
      tick();
      chk("prod_valid", 64'(out_valid), 64'd1);
      chk("prod_a", out_a, 64'h50);
      chk("prod_b", out_b, 64'h10);
      chk("prod_store", out_store, 64'h60);

      // ALU-after-ALU dependency: one bubble then forward from MEM
      instr(5'd7, 5'd3, 5'd31, 1'b0, '0);
      rf_rd1 = 64'hBAD;
      #1;
      chk("alu_dep_stall", 64'(in_ready), 64'd0);
      tick();
      chk("alu_dep_bubble", 64'(out_valid), 64'd0);
      mem_reg_write = 1; mem_rd = 5'd3; mem_data = 64'h77; mem_data_ok = 1;
      #1;
      chk("alu_dep_ready", 64'(in_ready), 64'd1);
      tick();
      chk("alu_dep_valid", 64'(out_valid), 64'd1);
      chk("alu_dep_a", out_a, 64'h77);
      chk("alu_dep_rd", 64'(out_rd), 64'd7);

      // load rd=4, then load-use: two bubbles, WB forward beats stale RF
      mem_reg_write = 0; mem_data_ok = 0;
      instr(5'd4, 5'd0, 5'd31, 1'b0, '0);
      tick();
      chk("load_rd", 64'(out_rd), 64'd4);
      instr(5'd8, 5'd4, 5'd31, 1'b0, '0);
      rf_rd1 = 64'h5555;
      #1;
      chk("lu_stall_ex", 64'(in_ready), 64'd0);
      tick();
      chk("lu_bubble1", 64'(out_valid), 64'd0);
      mem_reg_write = 1; mem_rd = 5'd4; mem_data_ok = 0; mem_data = 64'hFFFF;
      #1;
      chk("lu_stall_mem", 64'(in_ready), 64'd0);
      tick();
      chk("lu_bubble2", 64'(out_valid), 64'd0);
      mem_reg_write = 0;
      wb_reg_write = 1; wb_rd = 5'd4; wb_data = 64'h1234;
      #1;
      chk("lu_ready", 64'(in_ready), 64'd1);
      tick();
      chk("lu_valid", 64'(out_valid), 64'd1);
      chk("lu_a_wb", out_a, 64'h1234);
      wb_reg_write = 0;

      // backpressure for three cycles while MEM data toggles
      instr(5'd11, 5'd9, 5'd10, 1'b0, '0);
      out_ready = 0;
      mem_reg_write = 1; mem_data_ok = 1; mem_rd = 5'd9; mem_data = 64'hA0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         tick();
         chk("bp_hold_a", out_a, 64'h1234);
         chk("bp_hold_rd", 64'(out_rd), 64'd8);
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
         mem_data = mem_data ^ 64'hFF;
      end
      out_ready = 1;
      #1;
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      tick();
      chk("bp_new_a", out_a, 64'h5F);
      chk("bp_new_rd", 64'(out_rd), 64'd11);
      in_valid = 0;
      tick();
      chk("bp_one_only", 64'(out_valid), 64'd0);

      // zero register never stalls nor forwards
      instr(5'd12, 5'd31, 5'd31, 1'b0, '0);
      mem_reg_write = 1; mem_rd = 5'd31; mem_data_ok = 0; mem_data = 64'h99;
      #1;
      chk("zero_no_stall", 64'(in_ready), 64'd1);
      tick();
      chk("zero_valid", 64'(out_valid), 64'd1);
      chk("zero_a", out_a, 64'd0);

      // flush with an incoming instruction
      mem_reg_write = 0;
      instr(5'd13, 5'd1, 5'd2, 1'b0, '0);
      flush = 1;
      #1;
      chk("flush_ready", 64'(in_ready), 64'd0);
      tick();
      chk("flush_valid", 64'(out_valid), 64'd0);
      flush = 0;

      // randomized traffic against the model
      idle_inputs();
      reset = 1;
      tick();
      reset = 0;
      m_valid = 0; m_rw = 0; m_a = '0; m_b = '0; m_st = '0; m_rd = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         in_valid      = ($urandom_range(0, 3) != 0);
         in_rn         = rreg(); in_rm = rreg(); in_rd = rreg();
         in_reg_write  = $urandom_range(0, 1) != 0;
         in_use_imm    = $urandom_range(0, 1) != 0;
         in_uses_rm    = $urandom_range(0, 3) != 0;
         in_imm        = {$urandom, $urandom};
         rf_rd1        = {$urandom, $urandom};
         rf_rd2        = {$urandom, $urandom};
         mem_reg_write = $urandom_range(0, 1) != 0;
         mem_data_ok   = $urandom_range(0, 2) != 0;
         mem_rd        = rreg();
         mem_data      = {$urandom, $urandom};
         wb_reg_write  = $urandom_range(0, 1) != 0;
         wb_rd         = rreg();
         wb_data       = {$urandom, $urandom};
         flush         = ($urandom_range(0, 19) == 0);
         out_ready     = ($urandom_range(0, 3) != 0);
         #1;
         stall     = in_valid && (blocked(in_rn, 1'b1) || blocked(in_rm, in_uses_rm));
         adv       = !m_valid || out_ready;
         exp_ready = adv && !stall && !flush;
         chk("r_in_ready", 64'(in_ready), 64'(exp_ready));
         chk("r_rr1", 64'(rf_rr1), 64'(in_rn));
         chk("r_rr2", 64'(rf_rr2), 64'(in_rm));
         chk("r_valid", 64'(out_valid), 64'(m_valid));
         chk("r_a", out_a, m_a);
         chk("r_b", out_b, m_b);
         chk("r_store", out_store, m_st);
         chk("r_rd", 64'(out_rd), 64'(m_rd));
         chk("r_rw", 64'(out_reg_write), 64'(m_rw));
         if ($urandom_range(0, 99) == 0) begin
            #2 reset = 1;
            #1;
            chk("r_async_reset_valid", 64'(out_valid), 64'd0);
            chk("r_async_reset_a", out_a, 64'd0);
            m_valid = 0; m_rw = 0; m_a = '0; m_b = '0; m_st = '0; m_rd = '0;
            tick();
            reset = 0;
         end else begin
            if (flush) begin
               m_valid = 0;
            end else if (in_valid && exp_ready) begin
               rmv     = want(in_rm, in_uses_rm, rf_rd2);
               m_valid = 1;
               m_a     = want(in_rn, 1'b1, rf_rd1);
               m_b     = in_use_imm ? in_imm : rmv;
               m_st    = rmv;
               m_rd    = in_rd;
               m_rw    = in_reg_write;
            end else if (adv) begin
               m_valid = 0;
            end
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
